// File: rtl/alarm_pkg.sv
// Shared types, time constants and small arithmetic helpers for the alarm controller.
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZED = 2'd2
   } alarm_state_t;

   localparam int HOURS_PER_DAY = 24;
   localparam int MIN_PER_HOUR  = 60;

   // Adds delta (< 60) minutes to hour:min, wrapping 59->0 and 23->0.
   function automatic logic [11:0] hm_add(input logic [5:0] hr, input logic [5:0] mn,
                                          input int delta);
      logic [6:0] m;
      logic [5:0] h;
      m = {1'b0, mn} + 7'(delta);
      h = hr;
      if (m >= 7'(MIN_PER_HOUR)) begin
         m = m - 7'(MIN_PER_HOUR);
         h = h + 6'd1;
      end
      if (h >= 6'(HOURS_PER_DAY)) h = h - 6'(HOURS_PER_DAY);
      return {h, m[5:0]};
   endfunction

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [7:0] r;
      r[7:4] = 4'(v / 6'd10);
      r[3:0] = 4'(v % 6'd10);
      return r;
   endfunction

endpackage

// File: rtl/alarm_ctrl_btn_pulse.sv
// Rising-edge detector: one registered single-cycle pulse per button press.
module btn_pulse (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic prev;

   // Reset captures the live level so a button held through reset does not fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev  <= btn;
         pulse <= 1'b0;
      end else begin
         prev  <= btn;
         pulse <= btn & ~prev;
      end
   end

endmodule

// File: rtl/alarm_ctrl.sv
// Multi-slot alarm controller: slot registers, match encoder, ring/snooze FSM,
// ring timeout counter and registered BCD display.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int N_ALARMS   = 4,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_SEC   = 60,
   localparam int IDX_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
   localparam int SEL_W     = $clog2(N_ALARMS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          c_hour,
   input  logic [5:0]          c_min,
   input  logic [5:0]          c_sec,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [5:0]          wr_hour,
   input  logic [5:0]          wr_min,
   input  logic                wr_arm,
   input  logic                btn_mode,
   input  logic                btn_snooze,
   input  logic                btn_stop,
   output logic [3:0]          hr1,
   output logic [3:0]          hr2,
   output logic [3:0]          min1,
   output logic [3:0]          min2,
   output logic [SEL_W-1:0]    disp_sel,
   output logic                ring,
   output logic [IDX_W-1:0]    ring_idx,
   output logic                snoozed,
   output logic [N_ALARMS-1:0] armed
);

   logic [5:0]          slot_hour [N_ALARMS];
   logic [5:0]          slot_min  [N_ALARMS];
   logic [N_ALARMS-1:0] slot_arm;

   logic mode_p, snooze_p, stop_p;

   btn_pulse u_mode   (.clk(clk), .rst(rst), .btn(btn_mode),   .pulse(mode_p));
   btn_pulse u_snooze (.clk(clk), .rst(rst), .btn(btn_snooze), .pulse(snooze_p));
   btn_pulse u_stop   (.clk(clk), .rst(rst), .btn(btn_stop),   .pulse(stop_p));

   logic       wr_ok;
   assign wr_ok = wr_en && (wr_hour <= 6'(HOURS_PER_DAY - 1)) &&
                  (wr_min <= 6'(MIN_PER_HOUR - 1)) && (32'(wr_idx) < N_ALARMS);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ALARMS; i++) begin
            slot_hour[i] <= '0;
            slot_min[i]  <= '0;
         end
         slot_arm <= '0;
      end else if (wr_ok) begin
         slot_hour[wr_idx] <= wr_hour;
         slot_min[wr_idx]  <= wr_min;
         slot_arm[wr_idx]  <= wr_arm;
      end
   end

   assign armed = slot_arm;

   // Time-change events; reset loads the live inputs so nothing fires right after reset.
   logic [11:0] prev_hm;
   logic [5:0]  prev_sec;
   logic        min_evt, sec_evt;

   always_ff @(posedge clk) begin
      prev_hm  <= {c_hour, c_min};
      prev_sec <= c_sec;
   end

   assign min_evt = ({c_hour, c_min} != prev_hm);
   assign sec_evt = (c_sec != prev_sec);

   // Lowest armed slot wins: scanning downward lets the smallest index overwrite last.
   logic             match_hit;
   logic [IDX_W-1:0] match_idx;

   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      for (int i = N_ALARMS - 1; i >= 0; i--) begin
         if (slot_arm[i] && slot_hour[i] == c_hour && slot_min[i] == c_min) begin
            match_hit = 1'b1;
            match_idx = IDX_W'(i);
         end
      end
   end

   alarm_state_t     state, state_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic [7:0]       ring_cnt, cnt_nxt;
   logic [11:0]      snz_hm, snz_nxt;
   logic             timeout;

   assign timeout = sec_evt && (ring_cnt == 8'(RING_SEC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ring_idx <= '0;
         ring_cnt <= '0;
         snz_hm   <= '0;
      end else begin
         state    <= state_nxt;
         ring_idx <= idx_nxt;
         ring_cnt <= cnt_nxt;
         snz_hm   <= snz_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = ring_idx;
      cnt_nxt   = ring_cnt;
      snz_nxt   = snz_hm;
      case (state)
         ST_IDLE: begin
            if (min_evt && match_hit) begin
               state_nxt = ST_RINGING;
               idx_nxt   = match_idx;
               cnt_nxt   = '0;
            end
         end
         ST_RINGING: begin
            if (stop_p) begin
               state_nxt = ST_IDLE;
            end else if (snooze_p) begin
               state_nxt = ST_SNOOZED;
               snz_nxt   = hm_add(c_hour, c_min, SNOOZE_MIN);
            end else if (timeout) begin
               state_nxt = ST_IDLE;
            end else if (sec_evt) begin
               cnt_nxt = ring_cnt + 8'd1;
            end
         end
         ST_SNOOZED: begin
            if (stop_p) begin
               state_nxt = ST_IDLE;
            end else if (min_evt && match_hit) begin
               state_nxt = ST_RINGING;
               idx_nxt   = match_idx;
               cnt_nxt   = '0;
            end else if (min_evt && {c_hour, c_min} == snz_hm) begin
               state_nxt = ST_RINGING;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign ring    = (state == ST_RINGING);
   assign snoozed = (state == ST_SNOOZED);

   always_ff @(posedge clk) begin
      if (rst) begin
         disp_sel <= '0;
      end else if (mode_p) begin
         disp_sel <= (disp_sel == SEL_W'(N_ALARMS)) ? '0 : disp_sel + SEL_W'(1);
      end
   end

   logic [5:0] show_h, show_m;

   always_comb begin
      show_h = c_hour;
      show_m = c_min;
      for (int i = 0; i < N_ALARMS; i++) begin
         if (disp_sel == SEL_W'(i + 1)) begin
            show_h = slot_hour[i];
            show_m = slot_min[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {hr1, hr2}   <= '0;
         {min1, min2} <= '0;
      end else begin
         {hr1, hr2}   <= to_bcd(show_h);
         {min1, min2} <= to_bcd(show_m);
      end
   end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed scenarios plus randomized traffic against a minute-of-day reference model.
module tb_alarm_ctrl;

   localparam int N    = 4;
   localparam int SNZ  = 5;
   localparam int RSEC = 60;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] c_hour, c_min, c_sec;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [5:0] wr_hour, wr_min;
   logic       wr_arm;
   logic       btn_mode, btn_snooze, btn_stop;
   logic [3:0] hr1, hr2, min1, min2;
   logic [2:0] disp_sel;
   logic       ring;
   logic [1:0] ring_idx;
   logic       snoozed;
   logic [3:0] armed;

   int n_checks = 0;
   int n_pass   = 0;

   alarm_ctrl #(.N_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_SEC(RSEC)) dut (
      .clk(clk), .rst(rst), .c_hour(c_hour), .c_min(c_min), .c_sec(c_sec),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_hour(wr_hour), .wr_min(wr_min), .wr_arm(wr_arm),
      .btn_mode(btn_mode), .btn_snooze(btn_snooze), .btn_stop(btn_stop),
      .hr1(hr1), .hr2(hr2), .min1(min1), .min2(min2), .disp_sel(disp_sel),
      .ring(ring), .ring_idx(ring_idx), .snoozed(snoozed), .armed(armed)
   );

   always #5 clk = ~clk;

   // Reference model: times held as minute-of-day, mode 0 idle / 1 ringing / 2 snoozed.
   int m_slot [N];
   bit m_arm  [N];
   int m_mode, m_idx, m_secs, m_snz, m_sel;
   int m_prev_mod, m_prev_sec;
   bit m_pb [3];
   bit m_pulse [3];
   int m_dig [4];

   task automatic model_step();
      int now, match, shown;
      bit mevt, sevt;
      if (rst) begin
         for (int i = 0; i < N; i++) begin m_slot[i] = 0; m_arm[i] = 1'b0; end
         m_mode = 0; m_idx = 0; m_secs = 0; m_snz = 0; m_sel = 0;
         m_dig = '{0, 0, 0, 0};
         m_prev_mod = c_hour * 60 + c_min;
         m_prev_sec = c_sec;
         m_pb = '{btn_mode, btn_snooze, btn_stop};
         m_pulse = '{1'b0, 1'b0, 1'b0};
         return;
      end
      now  = c_hour * 60 + c_min;
      mevt = (now != m_prev_mod);
      sevt = (c_sec != m_prev_sec);
      shown = (m_sel == 0) ? now : m_slot[m_sel - 1];
      m_dig = '{(shown / 60) / 10, (shown / 60) % 10, (shown % 60) / 10, (shown % 60) % 10};
      match = -1;
      for (int i = N - 1; i >= 0; i--) if (m_arm[i] && m_slot[i] == now) match = i;
      case (m_mode)
         0: if (mevt && match >= 0) begin m_mode = 1; m_idx = match; m_secs = 0; end
         1: begin
            if (m_pulse[2]) m_mode = 0;
            else if (m_pulse[1]) begin m_mode = 2; m_snz = (now + SNZ) % 1440; end
            else if (sevt) begin
               m_secs++;
               if (m_secs >= RSEC) m_mode = 0;
            end
         end
         default: begin
            if (m_pulse[2]) m_mode = 0;
            else if (mevt && match >= 0) begin m_mode = 1; m_idx = match; m_secs = 0; end
            else if (mevt && now == m_snz) begin m_mode = 1; m_secs = 0; end
         end
      endcase
      if (m_pulse[0]) m_sel = (m_sel + 1) % (N + 1);
      if (wr_en && wr_hour < 24 && wr_min < 60) begin
         m_slot[wr_idx] = wr_hour * 60 + wr_min;
         m_arm[wr_idx]  = wr_arm;
      end
      m_pulse = '{btn_mode && !m_pb[0], btn_snooze && !m_pb[1], btn_stop && !m_pb[2]};
      m_pb    = '{btn_mode, btn_snooze, btn_stop};
      m_prev_mod = now;
      m_prev_sec = c_sec;
   endtask

   // Driver tasks: inputs change 1 time unit after an edge, outputs are read there too.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      c_hour = 6'(h); c_min = 6'(m); c_sec = 6'(s);
   endtask

   task automatic write_slot(input int idx, input int h, input int m, input bit arm);
      wr_en = 1'b1; wr_idx = 2'(idx); wr_hour = 6'(h); wr_min = 6'(m); wr_arm = arm;
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic press(input int which);
      if (which == 0) btn_mode = 1'b1;
      else if (which == 1) btn_snooze = 1'b1;
      else btn_stop = 1'b1;
      cycle();
      btn_mode = 1'b0; btn_snooze = 1'b0; btn_stop = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      cycle(); cycle();
      n_checks++;
      if ({ring, snoozed, ring_idx, armed, disp_sel, hr1, hr2, min1, min2} !== 27'd0)
         $display("FAIL reset_state: got ring=%b snz=%b idx=%0d armed=%b sel=%0d dig=%0d%0d%0d%0d want all zero",
                  ring, snoozed, ring_idx, armed, disp_sel, hr1, hr2, min1, min2);
      else n_pass++;
      rst = 1'b0;
      cycle();
      n_checks++;
      if ({hr1, hr2, min1, min2} !== {4'(c_hour / 10), 4'(c_hour % 10), 4'(c_min / 10), 4'(c_min % 10)} || ring !== 1'b0)
         $display("FAIL reset_clock_digits: got %0d%0d:%0d%0d ring=%b want %0d:%0d ring=0",
                  hr1, hr2, min1, min2, ring, c_hour, c_min);
      else n_pass++;
   endtask

   task automatic test_basic_match();
      write_slot(1, 7, 30, 1'b1);
      set_time(7, 29, 0); cycle();
      n_checks++;
      if (ring !== 1'b0) $display("FAIL basic_early: got ring=%b want 0", ring);
      else n_pass++;
      set_time(7, 30, 0); cycle();
      n_checks++;
      if ({ring, ring_idx} !== {1'b1, 2'd1})
         $display("FAIL basic_ring: got ring=%b idx=%0d want ring=1 idx=1", ring, ring_idx);
      else n_pass++;
      btn_stop = 1'b1; cycle(); btn_stop = 1'b0;
      n_checks++;
      if (ring !== 1'b1) $display("FAIL stop_latency: got ring=%b want 1 one cycle after press", ring);
      else n_pass++;
      cycle();
      n_checks++;
      if (ring !== 1'b0) $display("FAIL basic_stop: got ring=%b want 0", ring);
      else n_pass++;
   endtask

   task automatic test_snooze_wrap();
      write_slot(0, 23, 58, 1'b1);
      set_time(23, 57, 0); cycle();
      set_time(23, 58, 0); cycle();
      n_checks++;
      if ({ring, ring_idx} !== {1'b1, 2'd0})
         $display("FAIL snooze_ring: got ring=%b idx=%0d want ring=1 idx=0", ring, ring_idx);
      else n_pass++;
      press(1);
      n_checks++;
      if ({ring, snoozed} !== 2'b01)
         $display("FAIL snooze_enter: got ring=%b snoozed=%b want 0/1", ring, snoozed);
      else n_pass++;
      for (int t = 23 * 60 + 59; t < 24 * 60 + 3; t++) begin
         set_time((t / 60) % 24, t % 60, 0); cycle();
         n_checks++;
         if ({ring, snoozed} !== 2'b01)
            $display("FAIL snooze_early: at %0d:%0d got ring=%b snoozed=%b want 0/1",
                     (t / 60) % 24, t % 60, ring, snoozed);
         else n_pass++;
      end
      set_time(0, 3, 0); cycle();
      n_checks++;
      if ({ring, snoozed, ring_idx} !== {1'b1, 1'b0, 2'd0})
         $display("FAIL snooze_wake: got ring=%b snoozed=%b idx=%0d want 1/0/0", ring, snoozed, ring_idx);
      else n_pass++;
      press(2);
   endtask

   task automatic test_timeout();
      write_slot(0, 0, 0, 1'b0);
      set_time(7, 29, 0); cycle();
      set_time(7, 30, 0); cycle();
      for (int k = 1; k <= 63; k++) begin
         c_sec = 6'(k % 60); cycle();
         if (k == 59) begin
            n_checks++;
            if (ring !== 1'b1) $display("FAIL timeout_early: got ring=%b want 1 after 59 secs", ring);
            else n_pass++;
         end
         if (k >= 60) begin
            n_checks++;
            if (ring !== 1'b0) $display("FAIL timeout_fall: sec change %0d got ring=%b want 0", k, ring);
            else n_pass++;
         end
      end
   endtask

   task automatic test_priority();
      write_slot(1, 0, 0, 1'b0);
      write_slot(2, 12, 0, 1'b1);
      write_slot(3, 12, 0, 1'b1);
      set_time(11, 59, 0); cycle();
      set_time(12, 0, 0); cycle();
      n_checks++;
      if ({ring, ring_idx} !== {1'b1, 2'd2})
         $display("FAIL prio_lowest: got ring=%b idx=%0d want ring=1 idx=2", ring, ring_idx);
      else n_pass++;
      btn_stop = 1'b1; btn_snooze = 1'b1; cycle();
      btn_stop = 1'b0; btn_snooze = 1'b0; cycle();
      n_checks++;
      if ({ring, snoozed} !== 2'b00)
         $display("FAIL stop_over_snooze: got ring=%b snoozed=%b want 0/0", ring, snoozed);
      else n_pass++;
      write_slot(2, 0, 0, 1'b0);
      write_slot(3, 0, 0, 1'b0);
      set_time(11, 59, 0); cycle();
      set_time(12, 0, 0);
      write_slot(0, 12, 0, 1'b1);
      n_checks++;
      if ({ring, armed} !== {1'b0, 4'b0001})
         $display("FAIL write_same_cycle: got ring=%b armed=%b want ring=0 armed=0001", ring, armed);
      else n_pass++;
      cycle();
      n_checks++;
      if (ring !== 1'b0) $display("FAIL write_no_retrigger: got ring=%b want 0", ring);
      else n_pass++;
   endtask

   task automatic test_display();
      write_slot(0, 9, 5, 1'b0);
      for (int p = 1; p <= 5; p++) begin
         press(0);
         n_checks++;
         if (disp_sel !== 3'(p % 5)) $display("FAIL disp_cycle: press %0d got sel=%0d want %0d", p, disp_sel, p % 5);
         else n_pass++;
      end
      press(0);
      cycle();
      n_checks++;
      if ({disp_sel, hr1, hr2, min1, min2} !== {3'd1, 4'd0, 4'd9, 4'd0, 4'd5})
         $display("FAIL disp_slot: got sel=%0d dig=%0d%0d%0d%0d want sel=1 dig=0905", disp_sel, hr1, hr2, min1, min2);
      else n_pass++;
   endtask

   task automatic test_invalid_reset();
      write_slot(0, 24, 10, 1'b1);
      cycle();
      n_checks++;
      if ({hr1, hr2, min1, min2, armed[0]} !== {4'd0, 4'd9, 4'd0, 4'd5, 1'b0})
         $display("FAIL invalid_write: got dig=%0d%0d%0d%0d arm0=%b want 0905 arm0=0", hr1, hr2, min1, min2, armed[0]);
      else n_pass++;
      write_slot(1, 7, 30, 1'b1);
      set_time(7, 29, 0); cycle();
      set_time(7, 30, 0); cycle();
      n_checks++;
      if (ring !== 1'b1) $display("FAIL pre_reset_ring: got ring=%b want 1", ring);
      else n_pass++;
      rst = 1'b1; cycle(); rst = 1'b0;
      n_checks++;
      if ({ring, snoozed, armed, disp_sel} !== 9'd0)
         $display("FAIL reset_midring: got ring=%b snz=%b armed=%b sel=%0d want all zero", ring, snoozed, armed, disp_sel);
      else n_pass++;
      press(0); press(0);
      cycle();
      n_checks++;
      if ({disp_sel, hr1, hr2, min1, min2} !== {3'd2, 16'd0})
         $display("FAIL reset_slots: got sel=%0d dig=%0d%0d%0d%0d want sel=2 dig=0000", disp_sel, hr1, hr2, min1, min2);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [26:0] exp_v;
      logic [3:0]  ea;
      rst = 1'b1; cycle(); rst = 1'b0;
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 2) == 0) set_time($urandom_range(0, 1), $urandom_range(0, 3), c_sec);
         if ($urandom_range(0, 1) == 0) c_sec = 6'($urandom_range(0, 3));
         wr_en   = ($urandom_range(0, 5) == 0);
         wr_idx  = 2'($urandom_range(0, 3));
         wr_hour = ($urandom_range(0, 9) == 0) ? 6'd24 : 6'($urandom_range(0, 1));
         wr_min  = ($urandom_range(0, 9) == 0) ? 6'd60 : 6'($urandom_range(0, 3));
         wr_arm  = ($urandom_range(0, 3) != 0);
         btn_mode   = ($urandom_range(0, 5) == 0);
         btn_snooze = ($urandom_range(0, 7) == 0);
         btn_stop   = ($urandom_range(0, 11) == 0);
         cycle();
         for (int i = 0; i < N; i++) ea[i] = m_arm[i];
         exp_v = {m_mode == 1, m_mode == 2, 2'(m_idx), ea, 3'(m_sel),
                  4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])};
         n_checks++;
         if ({ring, snoozed, ring_idx, armed, disp_sel, hr1, hr2, min1, min2} !== exp_v)
            $display("FAIL random_cycle %0d: got %h want %h", n,
                     {ring, snoozed, ring_idx, armed, disp_sel, hr1, hr2, min1, min2}, exp_v);
         else n_pass++;
      end
      rst = 1'b0; wr_en = 1'b0;
      btn_mode = 1'b0; btn_snooze = 1'b0; btn_stop = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      c_hour = '0; c_min = '0; c_sec = '0;
      wr_en = 1'b0; wr_idx = '0; wr_hour = '0; wr_min = '0; wr_arm = 1'b0;
      btn_mode = 1'b0; btn_snooze = 1'b0; btn_stop = 1'b0;
      test_reset();
      test_basic_match();
      test_snooze_wrap();
      test_timeout();
      test_priority();
      test_display();
      test_invalid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
